// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner encoding and counter width.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed LS-over-IF priority with a starvation counter that forces an IF win after
// STARVE_LIMIT consecutive losses.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   if_req,
    input  logic   ls_req,
    input  logic   arb,
    output logic   win_valid,
    output owner_t win_owner
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        win_valid    = arb & (if_req | ls_req);
        win_owner    = OWN_IF;
        starve_cnt_d = starve_cnt_q;
        if (ls_req && !(if_req && starve_cnt_q == Limit)) begin
            win_owner = OWN_LS;
        end
        if (arb) begin
            if (!if_req || win_owner == OWN_IF) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != Limit) begin
                // Both requesting and LS won: IF lost one more round.
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store:
// arbitrate, drive one access cycle, count out latency, return data or a write ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 32,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_GNT,
    output logic          IF_VALID,
    output logic [DW-1:0] IF_RDATA,
    input  logic          LS_REQ,
    input  logic          LS_WE,
    input  logic [AW-1:0] LS_ADDR,
    input  logic [DW-1:0] LS_WDATA,
    output logic          LS_GNT,
    output logic          LS_VALID,
    output logic [DW-1:0] LS_RDATA,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          BUSY
);

    state_t           state_q, state_d;
    owner_t           owner_q;
    logic [AW-1:0]    addr_q;
    logic             we_q;
    logic [DW-1:0]    wdata_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [DW-1:0]    if_rdata_q, ls_rdata_q;

    logic   arb;
    logic   win_valid;
    owner_t win_owner;
    logic   wait_last;

    assign arb       = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign wait_last = (state_q == ST_WAIT) && (wait_cnt_q == '0);

    mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .CLK      (CLK),
        .RST      (RST),
        .if_req   (IF_REQ),
        .ls_req   (LS_REQ),
        .arb      (arb),
        .win_valid(win_valid),
        .win_owner(win_owner)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (win_valid) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_WAIT;
            ST_WAIT:   if (wait_last) state_d = ST_DONE;
            ST_DONE:   state_d = win_valid ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (win_valid) begin
                owner_q <= win_owner;
                addr_q  <= (win_owner == OWN_LS) ? LS_ADDR : IF_ADDR;
                we_q    <= (win_owner == OWN_LS) && LS_WE;
                // Fetches carry no data, so the write-data bus keeps its last value.
                if (win_owner == OWN_LS) wdata_q <= LS_WDATA;
            end
            if (state_q == ST_ACCESS) begin
                wait_cnt_q <= CNT_W'(WAIT_CYCLES - 1);
            end else if (state_q == ST_WAIT && wait_cnt_q != '0) begin
                wait_cnt_q <= wait_cnt_q - 1'b1;
            end
            if (wait_last && !we_q) begin
                if (owner_q == OWN_LS) ls_rdata_q <= MEM_RDATA;
                else                   if_rdata_q <= MEM_RDATA;
            end
        end
    end

    always_comb begin
        IF_GNT    = (state_q == ST_ACCESS) && (owner_q == OWN_IF);
        LS_GNT    = (state_q == ST_ACCESS) && (owner_q == OWN_LS);
        IF_VALID  = (state_q == ST_DONE) && (owner_q == OWN_IF);
        LS_VALID  = (state_q == ST_DONE) && (owner_q == OWN_LS);
        MEM_EN    = (state_q == ST_ACCESS);
        MEM_WE    = (state_q == ST_ACCESS) && we_q;
        MEM_ADDR  = addr_q;
        MEM_WDATA = wdata_q;
        IF_RDATA  = if_rdata_q;
        LS_RDATA  = ls_rdata_q;
        BUSY      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/completions, a negedge monitor pops them.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IF_REQ;
    logic [15:0] IF_ADDR;
    logic        IF_GNT, IF_VALID;
    logic [31:0] IF_RDATA;
    logic        LS_REQ, LS_WE;
    logic [15:0] LS_ADDR;
    logic [31:0] LS_WDATA;
    logic        LS_GNT, LS_VALID;
    logic [31:0] LS_RDATA;
    logic        MEM_EN, MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [31:0] MEM_WDATA, MEM_RDATA;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;  // 0 = IF, 1 = LS
        logic [31:0] data;  // expected RDATA of that port at completion
    } exp_t;

    exp_t exp_q[$];
    logic gnt_q[$];

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .AW(16), .DW(32), .WAIT_CYCLES(2), .STARVE_LIMIT(4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IF_REQ   (IF_REQ),
        .IF_ADDR  (IF_ADDR),
        .IF_GNT   (IF_GNT),
        .IF_VALID (IF_VALID),
        .IF_RDATA (IF_RDATA),
        .LS_REQ   (LS_REQ),
        .LS_WE    (LS_WE),
        .LS_ADDR  (LS_ADDR),
        .LS_WDATA (LS_WDATA),
        .LS_GNT   (LS_GNT),
        .LS_VALID (LS_VALID),
        .LS_RDATA (LS_RDATA),
        .MEM_EN   (MEM_EN),
        .MEM_WE   (MEM_WE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA),
        .BUSY     (BUSY)
    );

    // Memory model: read data visible in the second cycle after the MEM_EN cycle.
    logic [31:0] mem [0:255];
    logic        rd_v1 = 1'b0, rd_v2 = 1'b0;
    logic [31:0] rd_d1 = '0, rd_d2 = '0;

    always @(posedge CLK) begin
        if (RST) begin
            mem[8'h10] <= 32'hDEAD_BEEF;
            mem[8'h40] <= 32'h0000_CAFE;
        end else if (MEM_EN && MEM_WE) begin
            mem[MEM_ADDR[7:0]] <= MEM_WDATA;
        end
        rd_v1 <= MEM_EN && !MEM_WE;
        rd_d1 <= mem[MEM_ADDR[7:0]];
        rd_v2 <= rd_v1;
        rd_d2 <= rd_d1;
    end

    assign MEM_RDATA = rd_v2 ? rd_d2 : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor
    always @(negedge CLK) begin
        if (!RST) begin
            if (IF_GNT || LS_GNT) begin
                if (IF_GNT && LS_GNT) chk("gnt_exclusive", {IF_GNT, LS_GNT}, 32'd1);
                else if (gnt_q.size() == 0) chk("gnt_unexpected", {IF_GNT, LS_GNT}, 32'd0);
                else chk("gnt_owner", {31'd0, LS_GNT}, {31'd0, gnt_q.pop_front()});
            end
            if (IF_VALID || LS_VALID) begin
                if (IF_VALID && LS_VALID) begin
                    chk("valid_exclusive", {IF_VALID, LS_VALID}, 32'd1);
                end else if (exp_q.size() == 0) begin
                    chk("valid_unexpected", {IF_VALID, LS_VALID}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("valid_owner", {31'd0, LS_VALID}, {31'd0, e.port});
                    chk("valid_rdata", e.port ? LS_RDATA : IF_RDATA, e.data);
                end
            end
        end
    end

    initial begin
        RST = 1'b1; IF_REQ = 1'b0; IF_ADDR = '0;
        LS_REQ = 1'b0; LS_WE = 1'b0; LS_ADDR = '0; LS_WDATA = '0;
        tick(); tick();
        RST = 1'b0;
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_mem_en", {31'd0, MEM_EN}, 32'd0);
        chk("rst_mem_addr", {16'd0, MEM_ADDR}, 32'd0);
        chk("rst_mem_wdata", MEM_WDATA, 32'd0);
        chk("rst_if_rdata", IF_RDATA, 32'd0);
        chk("rst_ls_rdata", LS_RDATA, 32'd0);

        // 1. Single fetch
        IF_REQ = 1'b1; IF_ADDR = 16'h0010;
        gnt_q.push_back(1'b0); push_exp(1'b0, 32'hDEAD_BEEF);
        tick();
        chk("t1_if_gnt", {31'd0, IF_GNT}, 32'd1);
        chk("t1_mem_en", {31'd0, MEM_EN}, 32'd1);
        chk("t1_mem_we", {31'd0, MEM_WE}, 32'd0);
        chk("t1_mem_addr", {16'd0, MEM_ADDR}, 32'h0010);
        IF_REQ = 1'b0;
        tick();
        chk("t1_mem_en_off", {31'd0, MEM_EN}, 32'd0);
        tick(); tick();
        chk("t1_if_valid", {31'd0, IF_VALID}, 32'd1);
        chk("t1_if_rdata", IF_RDATA, 32'hDEAD_BEEF);
        tick();
        chk("t1_busy_low", {31'd0, BUSY}, 32'd0);

        // 2. Simultaneous requests: LS first, IF via DONE->ACCESS
        IF_REQ = 1'b1; IF_ADDR = 16'h0010;
        LS_REQ = 1'b1; LS_WE = 1'b0; LS_ADDR = 16'h0040;
        gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
        push_exp(1'b1, 32'h0000_CAFE); push_exp(1'b0, 32'hDEAD_BEEF);
        tick();
        chk("t2_ls_gnt", {31'd0, LS_GNT}, 32'd1);
        chk("t2_mem_addr", {16'd0, MEM_ADDR}, 32'h0040);
        LS_REQ = 1'b0;
        tick(); tick(); tick();
        chk("t2_ls_valid", {31'd0, LS_VALID}, 32'd1);
        chk("t2_ls_rdata", LS_RDATA, 32'h0000_CAFE);
        tick();
        chk("t2_if_gnt_c5", {31'd0, IF_GNT}, 32'd1);
        chk("t2_mem_addr_if", {16'd0, MEM_ADDR}, 32'h0010);
        IF_REQ = 1'b0;
        tick(); tick(); tick();
        chk("t2_if_valid_c8", {31'd0, IF_VALID}, 32'd1);
        tick();
        chk("t2_busy_low", {31'd0, BUSY}, 32'd0);

        // 3. Store, then load back through DONE->ACCESS
        LS_REQ = 1'b1; LS_WE = 1'b1; LS_ADDR = 16'h0020; LS_WDATA = 32'h1234_5678;
        gnt_q.push_back(1'b1); push_exp(1'b1, 32'h0000_CAFE);
        tick();
        chk("t3_mem_en", {31'd0, MEM_EN}, 32'd1);
        chk("t3_mem_we", {31'd0, MEM_WE}, 32'd1);
        chk("t3_mem_wdata", MEM_WDATA, 32'h1234_5678);
        LS_REQ = 1'b0; LS_WE = 1'b0;
        tick();
        chk("t3_mem_we_off", {31'd0, MEM_WE}, 32'd0);
        tick(); tick();
        chk("t3_ls_valid", {31'd0, LS_VALID}, 32'd1);
        chk("t3_ls_rdata_held", LS_RDATA, 32'h0000_CAFE);
        LS_REQ = 1'b1; LS_WE = 1'b0; LS_ADDR = 16'h0020;
        gnt_q.push_back(1'b1); push_exp(1'b1, 32'h1234_5678);
        tick();
        chk("t3_reload_gnt", {31'd0, LS_GNT}, 32'd1);
        LS_REQ = 1'b0;
        tick(); tick(); tick();
        chk("t3_reload_data", LS_RDATA, 32'h1234_5678);
        tick();

        // 4. Starvation: LS x4, IF, LS
        IF_REQ = 1'b1; IF_ADDR = 16'h0010;
        LS_REQ = 1'b1; LS_WE = 1'b0; LS_ADDR = 16'h0040;
        for (int k = 0; k < 6; k++) begin
            gnt_q.push_back(k != 4);
            if (k == 4) push_exp(1'b0, 32'hDEAD_BEEF);
            else        push_exp(1'b1, 32'h0000_CAFE);
        end
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c == 13) chk("t4_starve_full", {28'd0, dut.u_prio.starve_cnt_q}, 32'd4);
            if (c == 17) begin
                chk("t4_if_forced", {31'd0, IF_GNT}, 32'd1);
                chk("t4_starve_clr", {28'd0, dut.u_prio.starve_cnt_q}, 32'd0);
            end
            if (c == 21) chk("t4_ls_after_if", {31'd0, LS_GNT}, 32'd1);
        end
        IF_REQ = 1'b0; LS_REQ = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t4_busy_low", {31'd0, BUSY}, 32'd0);

        // 5. Reset during WAIT abandons the access
        LS_REQ = 1'b1; LS_WE = 1'b0; LS_ADDR = 16'h0040;
        gnt_q.push_back(1'b1);
        tick();
        chk("t5_ls_gnt", {31'd0, LS_GNT}, 32'd1);
        LS_REQ = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        chk("t5_busy_rst", {31'd0, BUSY}, 32'd0);
        chk("t5_mem_en_rst", {31'd0, MEM_EN}, 32'd0);
        RST = 1'b0;
        IF_REQ = 1'b1; IF_ADDR = 16'h0010;
        gnt_q.push_back(1'b0); push_exp(1'b0, 32'hDEAD_BEEF);
        tick();
        chk("t5_if_gnt", {31'd0, IF_GNT}, 32'd1);
        chk("t5_no_ls_valid", {31'd0, LS_VALID}, 32'd0);
        IF_REQ = 1'b0;
        tick(); tick(); tick();
        chk("t5_if_valid", {31'd0, IF_VALID}, 32'd1);
        chk("t5_if_rdata", IF_RDATA, 32'hDEAD_BEEF);
        tick();

        // 6a. IF request only during WAIT is ignored
        LS_REQ = 1'b1; LS_ADDR = 16'h0040;
        gnt_q.push_back(1'b1); push_exp(1'b1, 32'h0000_CAFE);
        tick();
        LS_REQ = 1'b0;
        tick();
        IF_REQ = 1'b1;
        chk("t6_ign_c2", {31'd0, IF_GNT}, 32'd0);
        tick();
        chk("t6_ign_c3", {31'd0, IF_GNT}, 32'd0);
        IF_REQ = 1'b0;
        tick();
        chk("t6_ls_valid", {31'd0, LS_VALID}, 32'd1);
        tick();
        chk("t6_idle_c5", {31'd0, BUSY}, 32'd0);
        chk("t6_no_gnt_c5", {31'd0, IF_GNT}, 32'd0);

        // 6b. IF request held into DONE is granted next cycle
        LS_REQ = 1'b1;
        gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
        push_exp(1'b1, 32'h0000_CAFE); push_exp(1'b0, 32'hDEAD_BEEF);
        tick();
        LS_REQ = 1'b0;
        tick();
        IF_REQ = 1'b1;
        tick(); tick();
        chk("t6_done_no_gnt", {31'd0, IF_GNT}, 32'd0);
        tick();
        chk("t6_if_gnt_c5", {31'd0, IF_GNT}, 32'd1);
        IF_REQ = 1'b0;
        tick(); tick(); tick();
        chk("t6_if_valid_c8", {31'd0, IF_VALID}, 32'd1);
        tick(); tick();

        chk("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences the CPU's single synchronous memory port and shares it between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Arbitrates between them, latches the winning request and drives the memory for one access cycle.
- Counts out the memory latency, then returns read data or a write acknowledgement to the owner.
- Sits between the control FSM's fetch/mem states and the memory model.

Parameters:
AW, 16, address width.
DW, 32, data width.
WAIT_CYCLES, 2, memory read latency in cycles after the MEM_EN cycle; legal range 1..15.
STARVE_LIMIT, 4, consecutive arbitrations IF may lose before it is forced to win; legal range 1..15.

Ports:
CLK  in  1  clock, all logic on rising edge.
RST  in  1  synchronous active-high reset.
IF_REQ  in  1  fetch request.
IF_ADDR  in  AW  fetch address.
IF_GNT  out  1  one-cycle grant pulse to IF.
IF_VALID  out  1  one-cycle pulse: IF_RDATA is new.
IF_RDATA  out  DW  fetched word, held until the next IF completion.
LS_REQ  in  1  load/store request.
LS_WE  in  1  1 = store, 0 = load.
LS_ADDR  in  AW  load/store address.
LS_WDATA  in  DW  store data.
LS_GNT  out  1  one-cycle grant pulse to LS.
LS_VALID  out  1  one-cycle pulse: load data ready, or store done.
LS_RDATA  out  DW  load word, held until the next LS load completion.
MEM_EN  out  1  memory access strobe.
MEM_WE  out  1  memory write enable.
MEM_ADDR  out  AW  memory address.
MEM_WDATA  out  DW  memory write data.
MEM_RDATA  in  DW  memory read data; valid WAIT_CYCLES cycles after the MEM_EN cycle.
BUSY  out  1  high when the state is not IDLE.

Behaviour:
- Reset (RST sampled high at a rising edge):
  - State becomes IDLE; owner becomes IF.
  - Wait and starve counters become 0.
  - All outputs become 0, including the RDATA and MEM_* registers.
  - Reset overrides every other event.
- States: IDLE -> ACCESS -> WAIT (WAIT_CYCLES cycles) -> DONE -> IDLE, or DONE -> ACCESS.
- Arbitration points: requests are sampled only at the edge that ends an IDLE or DONE cycle. REQ is ignored in ACCESS and WAIT.
- A requester holds REQ and its fields until it sees GNT, then may drop them. A REQ still high in DONE counts as a new request.
- Winner selection:
  - LS only -> LS.
  - IF only -> IF.
  - Both -> LS, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- Starve counter:
  - Increments when both request and LS wins, saturating at STARVE_LIMIT.
  - Clears when IF is granted or when IF_REQ is low at an arbitration point.
- On a win:
  - Latch owner, address, WE (forced 0 for IF) and WDATA.
  - Next cycle is ACCESS.
- ACCESS (exactly 1 cycle): owner's GNT = 1, MEM_EN = 1, MEM_WE = latched WE, MEM_ADDR and MEM_WDATA = latched values.
- MEM_EN is 0 in every other state; MEM_ADDR and MEM_WDATA hold their last values.
- WAIT:
  - wait_cnt loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - At wait_cnt == 0 the state moves to DONE. For a read, MEM_RDATA is captured into the owner's RDATA at that same edge.
  - Writes capture nothing.
- DONE (1 cycle):
  - Owner's VALID = 1. RDATA is already updated in this cycle.
  - Arbitrates exactly as IDLE. If there is a winner the next state is ACCESS, otherwise IDLE.
- Latency: request sampled at edge 0 -> GNT/MEM_EN in cycle 1 -> VALID in cycle 2+WAIT_CYCLES.
- Throughput: back-to-back, one access per WAIT_CYCLES+2 cycles.
- GNT and VALID never go to both ports in the same cycle. At most one access is in flight.
- Reset mid-ACCESS or mid-WAIT: the access is abandoned with no VALID pulse, and MEM_EN is 0 from the next cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding: ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE.
  - Owner encoding: OWN_IF = 0, OWN_LS = 1.
  - Counter width constant CNT_W = 4.
- One sub-module, mem_arb_prio: takes IF_REQ, LS_REQ and an arbitrate strobe; owns the starve counter; outputs win_valid and win_owner.

Test Plan:
(WAIT_CYCLES = 2, STARVE_LIMIT = 4, memory model returns data 2 cycles after MEM_EN.)
1. Single fetch: RST high 2 cycles, then IF_REQ with IF_ADDR = 0x0010, memory word 0xDEADBEEF -> cycle 1: IF_GNT = 1, MEM_EN = 1, MEM_WE = 0, MEM_ADDR = 0x0010; cycle 4: IF_VALID = 1, IF_RDATA = 0xDEADBEEF; BUSY low in cycle 5.
2. Simultaneous requests: IF (0x0010) and LS load (0x0040, word 0x0000CAFE) both raised at edge 0 -> LS_GNT in cycle 1, LS_VALID with 0x0000CAFE in cycle 4; IF_GNT in cycle 5 via DONE->ACCESS; IF_VALID in cycle 8.
3. Store: LS_WE = 1, LS_ADDR = 0x0020, LS_WDATA = 0x12345678 -> cycle 1: MEM_WE = 1, MEM_WDATA = 0x12345678; LS_VALID in cycle 4; LS_RDATA unchanged; a later load of 0x0020 returns 0x12345678.
4. Starvation: LS_REQ and IF_REQ held high continuously -> grants go LS, LS, LS, LS, then IF on the 5th grant, then LS again; starve counter back to 0 after the IF grant.
5. Reset mid-access: LS load granted in cycle 1, RST high in cycle 2 -> cycle 3: BUSY = 0, MEM_EN = 0, no LS_VALID ever; a fresh IF request afterwards completes with normal 4-cycle latency.
6. Ignored requests: IF_REQ pulsed only in cycles 2-3 while the LS access is in WAIT -> no IF_GNT; IF_REQ held into the DONE cycle -> granted in the following cycle.
